// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, owner constants and counter widths for bus_arbiter
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;
  localparam int WAIT_W = 3;
  localparam int BURST_W = 4;
  localparam int PERF_W = 16;
endpackage

// File: rtl/bus_arb_picker.sv
// bus_arb_picker: DMA-burst-limited winner selection between CPU and DMA requesters
module bus_arb_picker
  import bus_arb_pkg::*;
#(
  parameter int DMA_MAX_BURST = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic idle,
  input  logic cpu_req,
  input  logic dma_req,
  output logic grant,
  output logic owner
);
  logic [BURST_W-1:0] burst;
  logic cap;
  always_comb begin
    cap = burst == BURST_W'(DMA_MAX_BURST);
    grant = idle && (cpu_req || dma_req);
    owner = dma_req && !(cpu_req && cap) ? OWNER_DMA : OWNER_CPU;
  end
  always_ff @(posedge clock)
    if (reset || (idle && !dma_req) || (grant && owner == OWNER_CPU)) burst <= '0;
    else if (grant && cpu_req && !cap) burst <= burst + BURST_W'(1);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/DMA memory bus sequencer; BUS_ARBITER_PERF_COUNTERS_EN builds grant/contention counters
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DMA_MAX_BURST = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        grant_dma,
  output logic [15:0] perf_cpu_grants,
  output logic [15:0] perf_dma_grants,
  output logic [15:0] perf_contention
);
  state_t state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic grant, pick, done;
  bus_arb_picker #(.DMA_MAX_BURST(DMA_MAX_BURST)) u_picker (
    .clock(clock),
    .reset(reset),
    .idle(state == IDLE),
    .cpu_req(cpu_req),
    .dma_req(dma_req),
    .grant(grant),
    .owner(pick)
  );
  always_comb begin
    done = state == ACCESS && wait_cnt == '0;
    state_nx = state == IDLE ? (grant ? ACCESS : IDLE) : done ? ACK : state == ACCESS ? ACCESS : IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      grant_dma <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state <= state_nx;
      cpu_ack <= done && grant_dma == OWNER_CPU;
      dma_ack <= done && grant_dma == OWNER_DMA;
      if (grant) begin
        grant_dma <= pick;
        mem_we <= pick ? dma_we : cpu_we;
        mem_addr <= pick ? dma_addr : cpu_addr;
        mem_wdata <= pick ? dma_wdata : cpu_wdata;
        wait_cnt <= WAIT_W'(WAIT_STATES);
      end
      if (state == ACCESS && !done) wait_cnt <= wait_cnt - WAIT_W'(1);
      if (done) mem_we <= 1'b0;
      if (done && !mem_we && grant_dma == OWNER_CPU) cpu_rdata <= mem_rdata;
      if (done && !mem_we && grant_dma == OWNER_DMA) dma_rdata <= mem_rdata;
      if (state == ACK) grant_dma <= 1'b0;
    end
`ifdef BUS_ARBITER_PERF_COUNTERS_EN
  always_ff @(posedge clock)
    if (reset) begin
      perf_cpu_grants <= '0;
      perf_dma_grants <= '0;
      perf_contention <= '0;
    end else begin
      if (grant && pick == OWNER_CPU && ~&perf_cpu_grants) perf_cpu_grants <= perf_cpu_grants + PERF_W'(1);
      if (grant && pick == OWNER_DMA && ~&perf_dma_grants) perf_dma_grants <= perf_dma_grants + PERF_W'(1);
      if (cpu_req && (state == IDLE ? dma_req : grant_dma) && ~&perf_contention)
        perf_contention <= perf_contention + PERF_W'(1);
    end
`else
  assign perf_cpu_grants = '0;
  assign perf_dma_grants = '0;
  assign perf_contention = '0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven transfers with an ack-ordered scoreboard plus arbitration, abort and mid-transfer sequences
module tb_bus_arbiter;
  localparam int WS = 1;
  typedef struct {
    logic        dma;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } vec_t;
  logic clock = 1'b0, reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] cpu_addr = '0, dma_addr = '0;
  logic [7:0] cpu_wdata = '0, dma_wdata = '0, mem_rdata = '0;
  logic cpu_ack, dma_ack, mem_we, grant_dma;
  logic [7:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [15:0] mem_addr, perf_cpu_grants, perf_dma_grants, perf_contention;
  int checks = 0, errors = 0, n_cpu = 0, n_dma = 0;
  vec_t sb[$];
  vec_t tbl[6];
  logic [7:0] m_cpu_rd = '0, m_dma_rd = '0;
  bus_arbiter #(.WAIT_STATES(WS), .DMA_MAX_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .grant_dma(grant_dma),
    .perf_cpu_grants(perf_cpu_grants), .perf_dma_grants(perf_dma_grants), .perf_contention(perf_contention)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin
    vec_t e;
    if (reset) begin
      m_cpu_rd = '0;
      m_dma_rd = '0;
    end else if (cpu_ack || dma_ack) begin
      if (sb.size() == 0) check("unexpected_ack", 32'({cpu_ack, dma_ack}), 32'(0));
      else begin
        e = sb.pop_front();
        check("ack_owner", 32'({cpu_ack, dma_ack}), e.dma ? 32'(1) : 32'(2));
        if (!e.we && e.dma) m_dma_rd = e.rdata;
        if (!e.we && !e.dma) m_cpu_rd = e.rdata;
        check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
        check("dma_rdata", 32'(dma_rdata), 32'(m_dma_rd));
      end
    end
  end
  task automatic xfer(input vec_t v, input logic chg);
    int lat = 0, wec = 0;
    logic seen = 1'b0;
    @(negedge clock);
    if (v.dma) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata; n_dma++;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; n_cpu++;
    end
    mem_rdata = v.rdata;
    sb.push_back(v);
    while (!seen && lat < 20) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        check("addr_latched", 32'(mem_addr), 32'(v.addr));
        check("grant_dma_access", 32'(grant_dma), 32'(v.dma));
        if (v.we) check("wdata_latched", 32'(mem_wdata), 32'(v.wdata));
        if (chg) begin
          cpu_addr = 16'h0020; cpu_we = ~v.we; cpu_wdata = ~v.wdata;
          dma_addr = 16'h0020; dma_we = ~v.we; dma_wdata = ~v.wdata;
        end
      end
      if (mem_we) wec++;
      seen = cpu_ack || dma_ack;
    end
    check("latency", 32'(lat), 32'(WS + 2));
    check("we_cycles", 32'(wec), v.we ? 32'(WS + 1) : 32'(0));
    check("addr_hold_ack", 32'(mem_addr), 32'(v.addr));
    check("grant_dma_ack", 32'(grant_dma), 32'(v.dma));
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clock);
    check("ack_one_cycle", 32'({cpu_ack, dma_ack}), 32'(0));
    check("grant_idle", 32'(grant_dma), 32'(0));
    check("addr_idle_hold", 32'(mem_addr), 32'(v.addr));
  endtask
  initial begin
    int acks, cyc;
    logic stray;
    vec_t arb;
    tbl = '{
      '{1'b0, 1'b0, 16'h0100, 8'h00, 8'h5A},
      '{1'b1, 1'b1, 16'hF200, 8'hC3, 8'h77},
      '{1'b1, 1'b0, 16'h0000, 8'h00, 8'hFF},
      '{1'b0, 1'b1, 16'h8001, 8'h96, 8'h11},
      '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h00},
      '{1'b1, 1'b0, 16'h4321, 8'h00, 8'hA5}
    };
    repeat (3) @(negedge clock);
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_strobes", 32'({mem_we, cpu_ack, dma_ack, grant_dma}), 32'(0));
    check("rst_rdata", 32'({cpu_rdata, dma_rdata, mem_wdata}), 32'(0));
    reset = 1'b0;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hAA;
    @(negedge clock);
    check("abort_pre_we", 32'(mem_we), 32'(1));
    reset = 1'b1;
    @(negedge clock);
    check("abort_we", 32'(mem_we), 32'(0));
    check("abort_outputs", 32'({cpu_ack, dma_ack, grant_dma}), 32'(0));
    check("abort_addr", 32'(mem_addr), 32'(0));
    reset = 1'b0;
    cpu_req = 1'b0;
    stray = 1'b0;
    repeat (4) begin
      @(negedge clock);
      stray = stray | cpu_ack | dma_ack | mem_we;
    end
    check("abort_no_ack", 32'(stray), 32'(0));
    xfer('{1'b0, 1'b1, 16'h1234, 8'h5A, 8'h00}, 1'b0);
    for (int i = 0; i < 6; i++) xfer(tbl[i], 1'b0);
    xfer('{1'b0, 1'b0, 16'h0010, 8'h00, 8'h3C}, 1'b1);
    xfer('{1'b1, 1'b1, 16'h0010, 8'h5E, 8'h00}, 1'b1);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC000; cpu_wdata = 8'h01;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hD000; dma_wdata = 8'h02;
    for (int i = 0; i < 10; i++) begin
      arb.dma = (i % 5) != 4;
      arb.we = 1'b1;
      arb.addr = arb.dma ? 16'hD000 : 16'hC000;
      arb.wdata = '0;
      arb.rdata = '0;
      sb.push_back(arb);
      if (arb.dma) n_dma++;
      else n_cpu++;
    end
    acks = 0;
    cyc = 0;
    while (acks < 10 && cyc < 300) begin
      @(negedge clock);
      cyc++;
      if (cpu_ack || dma_ack) acks++;
    end
    check("arb_acks", 32'(acks), 32'(10));
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (3) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'(0));
`ifdef BUS_ARBITER_PERF_COUNTERS_EN
    check("perf_cpu", 32'(perf_cpu_grants), 32'(n_cpu));
    check("perf_dma", 32'(perf_dma_grants), 32'(n_dma));
    check("perf_contention_min", 32'(perf_contention >= 16'd2), 32'(1));
`else
    check("perf_off", 32'({perf_cpu_grants, perf_dma_grants}), 32'(0));
    check("perf_off_cont", 32'(perf_contention), 32'(0));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
